// File: rtl/controller_pkg.sv
// Shared encodings for the multi-cycle RV32I controller:
// ALU, ImmSrc, opcode, funct3, mux select codes and the FSM state type.
package controller_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_AND  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_PASS = 4'b1010;
  localparam logic [3:0] ALU_SUBU = 4'b1011;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_XORID  = 7'b0001011;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;
  localparam logic [2:0] IMM_R = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_W    = 2'b01;
  localparam logic [1:0] MW_H    = 2'b10;
  localparam logic [1:0] MW_B    = 2'b11;

  localparam logic [1:0] RS_W = 2'b01;
  localparam logic [1:0] RS_H = 2'b10;
  localparam logic [1:0] RS_B = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RWS_ALUOUT = 2'b00;
  localparam logic [1:0] RWS_LINK   = 2'b01;
  localparam logic [1:0] RWS_IMM    = 2'b10;
  localparam logic [1:0] RWS_MEM    = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXEC,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_UPPER
  } state_e;

  typedef enum logic [2:0] {
    AOP_ADD,
    AOP_BRANCH,
    AOP_RTYPE,
    AOP_ITYPE,
    AOP_XORID
  } alu_op_e;

endpackage

// File: rtl/alu_decoder.sv
// ALU control decode: opcode class, funct3, funct7_5 -> ALUControl.
// Ports: op_i, funct3_i, funct7_5_i in; alu_ctrl_o out.
module alu_decoder
  import controller_pkg::*;
(
  input  alu_op_e    op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output logic [3:0] alu_ctrl_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    unique case (op_i)
      AOP_BRANCH: begin
        case (funct3_i)
          F3_BEQ, F3_BNE:   alu_ctrl_o = ALU_SUB;
          F3_BLT, F3_BGE:   alu_ctrl_o = ALU_SLT;
          F3_BLTU, F3_BGEU: alu_ctrl_o = ALU_SLTU;
          default:          alu_ctrl_o = ALU_ADD;
        endcase
      end
      AOP_RTYPE, AOP_ITYPE: begin
        unique case (funct3_i)
          // bit 30 of an I-type is immediate data, not a SUB flag
          F3_ADD: alu_ctrl_o =
            (op_i == AOP_RTYPE && funct7_5_i)
            ? ALU_SUB : ALU_ADD;
          F3_SLL:  alu_ctrl_o = ALU_SLL;
          F3_SLT:  alu_ctrl_o = ALU_SLT;
          F3_SLTU: alu_ctrl_o = ALU_SLTU;
          F3_XOR:  alu_ctrl_o = ALU_XOR;
          F3_SR:   alu_ctrl_o =
            funct7_5_i ? ALU_SRA : ALU_SRL;
          F3_OR:   alu_ctrl_o = ALU_OR;
          F3_AND:  alu_ctrl_o = ALU_AND;
          default: alu_ctrl_o = ALU_ADD;
        endcase
      end
      AOP_XORID: alu_ctrl_o = ALU_XOR;
      default:   alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RV32I core with a shared memory port.
// Ports: clk, reset, Instr, Zero, mem_ready in; datapath controls out.
module multicycle_controller
  import controller_pkg::*;
#(
  parameter int RESET_STATE_FETCH = 1
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [31:0] Zero,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemRead,
  output logic [1:0]  MemWrite,
  output logic [1:0]  ResultSrc,
  output logic        AdrSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic        PCSrc,
  output logic [1:0]  regWriteSource,
  output logic [3:0]  ALUControl,
  output logic [2:0]  ImmSrc,
  output logic        xorid,
  output logic        instr_done,
  output logic        illegal
);

  // Only the fetch entry point exists; the parameter just names it.
  localparam state_e ST_RST =
    (RESET_STATE_FETCH != 0) ? S_FETCH : S_FETCH;

  state_e state_q, state_d;
  alu_op_e alu_op;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7_5;
  logic       res_zero;
  logic       taken;
  logic       unused_instr;

  assign opcode   = Instr[6:0];
  assign funct3   = Instr[14:12];
  assign f7_5     = Instr[30];
  assign res_zero = (Zero == 32'd0);
  assign unused_instr =
    ^{Instr[31], Instr[29:15], Instr[11:7]};

  logic is_load, is_store, is_r, is_i;
  logic is_br, is_jal, is_jalr;
  logic is_lui, is_auipc, is_xorid;

  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign is_r     = (opcode == OP_RTYPE);
  assign is_i     = (opcode == OP_ITYPE);
  assign is_br    = (opcode == OP_BRANCH);
  assign is_jal   = (opcode == OP_JAL);
  assign is_jalr  = (opcode == OP_JALR);
  assign is_lui   = (opcode == OP_LUI);
  assign is_auipc = (opcode == OP_AUIPC);
  assign is_xorid = (opcode == OP_XORID);

  alu_decoder u_alu_dec (
    .op_i       (alu_op),
    .funct3_i   (funct3),
    .funct7_5_i (f7_5),
    .alu_ctrl_o (ALUControl)
  );

  always_comb begin
    case (funct3)
      F3_BEQ:           taken = res_zero;
      F3_BNE:           taken = !res_zero;
      F3_BLT, F3_BLTU:  taken = Zero[0];
      F3_BGE, F3_BGEU:  taken = !Zero[0];
      default:          taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    alu_op         = AOP_ADD;
    PCWrite        = 1'b0;
    IRWrite        = 1'b0;
    RegWrite       = 1'b0;
    MemRead        = 1'b0;
    MemWrite       = MW_NONE;
    ResultSrc      = 2'b00;
    AdrSrc         = 1'b0;
    ALUSrcA        = SRCA_PC;
    ALUSrcB        = SRCB_RS2;
    PCSrc          = 1'b0;
    regWriteSource = RWS_ALUOUT;
    ImmSrc         = IMM_I;
    xorid          = 1'b0;
    instr_done     = 1'b0;
    illegal        = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        unique case (1'b1)
          is_br:              ImmSrc = IMM_B;
          is_jal:             ImmSrc = IMM_J;
          is_lui, is_auipc:   ImmSrc = IMM_U;
          default:            ImmSrc = IMM_I;
        endcase
        unique case (1'b1)
          is_load, is_store:    state_d = S_MEMADR;
          is_r, is_i, is_xorid: state_d = S_EXEC;
          is_br:                state_d = S_BRANCH;
          is_jal:               state_d = S_JAL;
          is_jalr:              state_d = S_JALR;
          is_lui, is_auipc:     state_d = S_UPPER;
          default: begin
            state_d    = S_FETCH;
            illegal    = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = is_store ? IMM_S : IMM_I;
        state_d = is_store ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        MemRead = 1'b1;
        AdrSrc  = 1'b1;
        unique case (funct3)
          F3_LB, F3_LBU: ResultSrc = RS_B;
          F3_LH, F3_LHU: ResultSrc = RS_H;
          default:       ResultSrc = RS_W;
        endcase
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite       = 1'b1;
        regWriteSource = RWS_MEM;
        instr_done     = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        unique case (funct3)
          F3_SB:   MemWrite = MW_B;
          F3_SH:   MemWrite = MW_H;
          default: MemWrite = MW_W;
        endcase
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_EXEC: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = is_r ? SRCB_RS2 : SRCB_IMM;
        unique case (1'b1)
          is_r:     alu_op = AOP_RTYPE;
          is_xorid: alu_op = AOP_XORID;
          default:  alu_op = AOP_ITYPE;
        endcase
        xorid   = is_xorid;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite       = 1'b1;
        regWriteSource = RWS_ALUOUT;
        instr_done     = 1'b1;
        state_d        = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        alu_op     = AOP_BRANCH;
        PCSrc      = 1'b1;
        PCWrite    = taken;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        PCWrite        = 1'b1;
        PCSrc          = 1'b1;
        RegWrite       = 1'b1;
        regWriteSource = RWS_LINK;
        instr_done     = 1'b1;
        state_d        = S_FETCH;
      end
      S_JALR: begin
        ALUSrcA        = SRCA_RS1;
        ALUSrcB        = SRCB_IMM;
        PCWrite        = 1'b1;
        RegWrite       = 1'b1;
        regWriteSource = RWS_LINK;
        instr_done     = 1'b1;
        state_d        = S_FETCH;
      end
      S_UPPER: begin
        RegWrite       = 1'b1;
        regWriteSource = is_lui ? RWS_IMM : RWS_ALUOUT;
        instr_done     = 1'b1;
        state_d        = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // reset aborts any access: no enable may fire this cycle
    if (reset) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = MW_NONE;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RST;
    else       state_q <= state_d;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller.
// Per-cycle expected control vectors are queued with their stimulus.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic [31:0] Zero;
  logic        mem_ready;
  logic        PCWrite, IRWrite, RegWrite, MemRead;
  logic [1:0]  MemWrite, ResultSrc;
  logic        AdrSrc;
  logic [1:0]  ALUSrcA, ALUSrcB;
  logic        PCSrc;
  logic [1:0]  regWriteSource;
  logic [3:0]  ALUControl;
  logic [2:0]  ImmSrc;
  logic        xorid, instr_done, illegal;

  always #5 clk = ~clk;

  multicycle_controller #(.RESET_STATE_FETCH(1)) dut (
    .clk            (clk),
    .reset          (reset),
    .Instr          (Instr),
    .Zero           (Zero),
    .mem_ready      (mem_ready),
    .PCWrite        (PCWrite),
    .IRWrite        (IRWrite),
    .RegWrite       (RegWrite),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .ResultSrc      (ResultSrc),
    .AdrSrc         (AdrSrc),
    .ALUSrcA        (ALUSrcA),
    .ALUSrcB        (ALUSrcB),
    .PCSrc          (PCSrc),
    .regWriteSource (regWriteSource),
    .ALUControl     (ALUControl),
    .ImmSrc         (ImmSrc),
    .xorid          (xorid),
    .instr_done     (instr_done),
    .illegal        (illegal)
  );

  typedef logic [25:0] vec_t;

  typedef struct packed {
    vec_t        e;
    logic        rst;
    logic        rdy;
    logic [31:0] z;
  } item_t;

  item_t item_q[$];
  string tag_q[$];
  int    checks   = 0;
  int    failures = 0;

  vec_t obs;
  assign obs = {PCWrite, IRWrite, RegWrite, MemRead,
                MemWrite, ResultSrc, AdrSrc,
                ALUSrcA, ALUSrcB, PCSrc, regWriteSource,
                ALUControl, ImmSrc, xorid, instr_done,
                illegal};

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic vec_t mk(
    int pcw, int irw, int rw, int mr, int mw, int rs,
    int adr, int sa, int sb, int pcs, int rws,
    int alu, int imm, int xid, int done, int ill);
    return {pcw[0], irw[0], rw[0], mr[0], mw[1:0],
            rs[1:0], adr[0], sa[1:0], sb[1:0], pcs[0],
            rws[1:0], alu[3:0], imm[2:0], xid[0],
            done[0], ill[0]};
  endfunction

  function automatic vec_t f_wait();
    return mk(0,0,0,1, 0,0,0, 0,2,0, 0,0,0, 0,0,0);
  endfunction

  function automatic vec_t f_go();
    return mk(1,1,0,1, 0,0,0, 0,2,0, 0,0,0, 0,0,0);
  endfunction

  function automatic vec_t dec(int imm);
    return mk(0,0,0,0, 0,0,0, 1,1,0, 0,0,imm, 0,0,0);
  endfunction

  function automatic vec_t alu_wb();
    return mk(0,0,1,0, 0,0,0, 0,0,0, 0,0,0, 0,1,0);
  endfunction

  task automatic push(string tag, vec_t e, bit rdy = 1'b1,
                      logic [31:0] z = 32'd0,
                      bit rst = 1'b0);
    item_t it;
    it.e = e; it.rst = rst; it.rdy = rdy; it.z = z;
    item_q.push_back(it);
    tag_q.push_back(tag);
  endtask

  // one queued item per clock: drive, sample at negedge, compare
  task automatic drain();
    item_t it;
    string tg;
    while (item_q.size() > 0) begin
      it = item_q.pop_front();
      tg = tag_q.pop_front();
      reset     = it.rst;
      mem_ready = it.rdy;
      Zero      = it.z;
      @(negedge clk);
      chk(tg, {6'd0, obs}, {6'd0, it.e});
      @(posedge clk);
      #1;
    end
  endtask

  task automatic branch(string tag, logic [31:0] ins,
                        logic [31:0] z, int pcw, int alu);
    Instr = ins;
    push({tag, "_f"}, f_go());
    push({tag, "_d"}, dec(2));
    push({tag, "_br"},
         mk(pcw,0,0,0, 0,0,0, 2,0,1, 0,alu,0, 0,1,0),
         1'b1, z);
    drain();
  endtask

  task automatic alu_op(string tag, logic [31:0] ins,
                        int sb, int alu, int xid);
    Instr = ins;
    push({tag, "_f"}, f_go());
    push({tag, "_d"}, dec(0));
    push({tag, "_ex"},
         mk(0,0,0,0, 0,0,0, 2,sb,0, 0,alu,0, xid,0,0),
         1'b0);
    push({tag, "_wb"}, alu_wb());
    drain();
  endtask

  initial begin
    reset = 1'b1; Instr = 32'd0;
    Zero = 32'd0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    push("reset", mk(0,0,0,0, 0,0,0, 0,2,0, 0,0,0, 0,0,0),
         1'b1, 32'd0, 1'b1);
    drain();

    // ADD x3,x1,x2 with two fetch wait cycles
    Instr = 32'h002081B3;
    push("add_fw1", f_wait(), 1'b0);
    push("add_fw2", f_wait(), 1'b0);
    push("add_f", f_go());
    push("add_d", dec(0));
    push("add_ex",
         mk(0,0,0,0, 0,0,0, 2,0,0, 0,0,0, 0,0,0));
    push("add_wb", alu_wb());
    drain();

    alu_op("sub",   32'h402081B3, 0, 4'b0001, 0);
    alu_op("srai",  32'h4030D093, 1, 4'b1001, 0);
    alu_op("addi",  32'h40000093, 1, 4'b0000, 0);
    alu_op("xorid", 32'h0020C08B, 1, 4'b0100, 1);

    // SB with three memory wait cycles
    Instr = 32'h00208023;
    push("sb_f", f_go());
    push("sb_d", dec(0));
    push("sb_adr",
         mk(0,0,0,0, 0,0,0, 2,1,0, 0,0,1, 0,0,0));
    for (int i = 0; i < 3; i++)
      push("sb_wait",
           mk(0,0,0,0, 3,0,1, 0,0,0, 0,0,0, 0,0,0), 1'b0);
    push("sb_done",
         mk(0,0,0,0, 3,0,1, 0,0,0, 0,0,0, 0,1,0));
    drain();

    // LW with one memory wait cycle
    Instr = 32'h0000A103;
    push("lw_f", f_go());
    push("lw_d", dec(0));
    push("lw_adr",
         mk(0,0,0,0, 0,0,0, 2,1,0, 0,0,0, 0,0,0));
    push("lw_wait",
         mk(0,0,0,1, 0,1,1, 0,0,0, 0,0,0, 0,0,0), 1'b0);
    push("lw_rd",
         mk(0,0,0,1, 0,1,1, 0,0,0, 0,0,0, 0,0,0));
    push("lw_wb",
         mk(0,0,1,0, 0,0,0, 0,0,0, 3,0,0, 0,1,0));
    drain();

    branch("beq_t",  32'h00208463, 32'd0, 1, 4'b0001);
    branch("beq_n",  32'h00208463, 32'd5, 0, 4'b0001);
    branch("bne_n",  32'h00209463, 32'd0, 0, 4'b0001);
    branch("bltu_t", 32'h0020E463, 32'd1, 1, 4'b0011);
    branch("bge_n",  32'h0020D463, 32'd1, 0, 4'b0010);

    Instr = 32'h008000EF;
    push("jal_f", f_go());
    push("jal_d", dec(4));
    push("jal_x",
         mk(1,0,1,0, 0,0,0, 0,0,1, 1,0,0, 0,1,0));
    drain();

    Instr = 32'h000080E7;
    push("jalr_f", f_go());
    push("jalr_d", dec(0));
    push("jalr_x",
         mk(1,0,1,0, 0,0,0, 2,1,0, 1,0,0, 0,1,0));
    drain();

    Instr = 32'h123450B7;
    push("lui_f", f_go());
    push("lui_d", dec(3));
    push("lui_u",
         mk(0,0,1,0, 0,0,0, 0,0,0, 2,0,0, 0,1,0));
    drain();

    Instr = 32'h12345097;
    push("auipc_f", f_go());
    push("auipc_d", dec(3));
    push("auipc_u",
         mk(0,0,1,0, 0,0,0, 0,0,0, 0,0,0, 0,1,0));
    drain();

    Instr = 32'h0000007F;
    push("ill_f", f_go());
    push("ill_d",
         mk(0,0,0,0, 0,0,0, 1,1,0, 0,0,0, 0,1,1));
    drain();

    // LH interrupted by reset while in S_MEMREAD
    Instr = 32'h00009103;
    push("rlh_f", f_go());
    push("rlh_d", dec(0));
    push("rlh_adr",
         mk(0,0,0,0, 0,0,0, 2,1,0, 0,0,0, 0,0,0));
    push("rlh_rst",
         mk(0,0,0,0, 0,2,1, 0,0,0, 0,0,0, 0,0,0),
         1'b1, 32'd0, 1'b1);
    push("rlh_fetch", f_wait(), 1'b0);
    push("rlh_f2", f_go());
    drain();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
